// File: rtl/sum_accumulator_pkg.sv
// Shared types and defaults for the multi-operand accumulation controller.
package sum_acc_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sum_accumulator_if.sv
// Operand handshake between the operand source and the accumulator.
interface sum_accumulator_if
  import sum_acc_pkg::*;
#(
  parameter int N = DEFAULT_N
) ();

  logic         op_valid;
  logic [N-1:0] op_data;
  logic         op_ready;

  modport master (output op_valid, output op_data, input op_ready);
  modport slave  (input op_valid, input op_data, output op_ready);

endinterface

// File: rtl/op_sum.sv
// Reusable N-bit adder with carry in/out; instantiated beside the accumulator.
module op_sum #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         c_in,
  output logic [N-1:0] Z,
  output logic         c_out
);

  assign {c_out, Z} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a programmed number of operands through an external op_sum adder,
// keeping sticky carry/overflow flags and pulsing done at the end of a run.
//
//   state | meaning
//   IDLE  | waiting for start; result and flags hold
//   ACCUM | op_ready high, each accepted operand is added to the total
//   DONE  | one-cycle done pulse, then back to IDLE
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter  int N       = DEFAULT_N,
  parameter  int MAX_OPS = 8,
  localparam int CW      = $clog2(MAX_OPS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CW-1:0]      num_ops,
  sum_accumulator_if.slave   op,
  output logic [N-1:0]       sum_a,
  output logic [N-1:0]       sum_b,
  output logic               sum_cin,
  input  logic [N-1:0]       sum_z,
  input  logic               sum_cout,
  output logic [N-1:0]       result,
  output logic               carry,
  output logic               overflow,
  output logic               zero,
  output logic               neg,
  output logic               busy,
  output logic               done
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OPS);

  state_t        r_state;
  logic [N-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_ovf;

  logic          w_accept;
  logic          w_ovf;
  logic [CW-1:0] w_num_ops;

  assign w_accept  = op.op_valid & op.op_ready;
  assign w_ovf     = (sum_a[N-1] == sum_b[N-1]) && (sum_z[N-1] != sum_a[N-1]);
  // Only reachable when MAX_OPS is not of the form 2^CW-1.
  assign w_num_ops = (num_ops > MAX_CNT) ? MAX_CNT : num_ops;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= w_num_ops;
            r_state <= (w_num_ops == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc   <= sum_z;
            r_carry <= r_carry | sum_cout;
            r_ovf   <= r_ovf | w_ovf;
            r_cnt   <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign op.op_ready = (r_state == ACCUM);

  assign sum_a    = r_acc;
  assign sum_b    = op.op_data;
  assign sum_cin  = 1'b0;

  assign result   = r_acc;
  assign carry    = r_carry;
  assign overflow = r_ovf;
  assign zero     = (r_acc == '0);
  assign neg      = r_acc[N-1];
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator wired to op_sum.
module tb_sum_accumulator;
  import sum_acc_pkg::*;

  localparam int N       = 4;
  localparam int MAX_OPS = 8;
  localparam int CW      = $clog2(MAX_OPS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_ops;
  logic [N-1:0]  sum_a, sum_b, sum_z;
  logic          sum_cin, sum_cout;
  logic [N-1:0]  result;
  logic          carry, overflow, zero, neg, busy, done;

  sum_accumulator_if #(.N(N)) op_if ();

  sum_accumulator #(.N(N), .MAX_OPS(MAX_OPS)) dut (
    .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .op(op_if.slave),
    .sum_a(sum_a), .sum_b(sum_b), .sum_cin(sum_cin), .sum_z(sum_z), .sum_cout(sum_cout),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero), .neg(neg),
    .busy(busy), .done(done)
  );

  op_sum #(.N(N)) u_add (
    .A(sum_a), .B(sum_b), .c_in(sum_cin), .Z(sum_z), .c_out(sum_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [N-1:0] ops_q[$];
  int           n_vec  = 0;
  int           n_bad  = 0;
  int           n_done = 0;
  int           n_runs = 0;
  logic         prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      chk("done_width", 32'(prev_done), 0);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("sb_result", 32'(result), 32'(mon_e.res));
        chk("sb_carry", 32'(carry), 32'(mon_e.c));
        chk("sb_ovf", 32'(overflow), 32'(mon_e.v));
      end else begin
        chk("sb_underflow", 32'(sb.size()), 1);
      end
    end
    prev_done = done;
  end

  // Drives one run from ops_q; gap idle cycles (with a stray start) precede each op after the first.
  task automatic run(input int num, input int gap);
    int           eff;
    logic [N-1:0] acc, b;
    logic [N:0]   s;
    logic         c, v;
    logic [N-1:0] part[MAX_OPS];
    eff = (num > MAX_OPS) ? MAX_OPS : num;
    acc = '0; c = 1'b0; v = 1'b0;
    for (int i = 0; i < eff; i++) begin
      b    = ops_q[i];
      s    = {1'b0, acc} + {1'b0, b};
      v    = v | ((acc[N-1] == b[N-1]) && (s[N-1] != acc[N-1]));
      c    = c | s[N];
      part[i] = acc;
      acc  = s[N-1:0];
    end
    @(negedge clk);
    start   = 1'b1;
    num_ops = CW'(num);
    sb.push_back('{res: acc, c: c, v: v});
    n_runs++;
    @(negedge clk);
    start = 1'b0;
    if (eff == 0) begin
      chk("zero_done", 32'(done), 1);
      chk("zero_rdy", 32'(op_if.op_ready), 0);
      @(negedge clk);
      chk("zero_idle", 32'(busy), 0);
      chk("zero_rdy2", 32'(op_if.op_ready), 0);
      return;
    end
    chk("rdy_lat", 32'(op_if.op_ready), 1);
    for (int i = 0; i < eff; i++) begin
      if (i > 0 && gap > 0) begin
        op_if.op_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          start   = 1'b1;
          num_ops = CW'($urandom_range(0, MAX_OPS));
          @(negedge clk);
        end
        start = 1'b0;
        chk("gap_hold", 32'(result), 32'(part[i]));
        chk("gap_busy", 32'(busy), 1);
      end
      op_if.op_valid = 1'b1;
      op_if.op_data  = ops_q[i];
      @(negedge clk);
      if (i < eff - 1) chk("early_done", 32'(done), 0);
    end
    op_if.op_valid = 1'b0;
    chk("done_lat", 32'(done), 1);
    chk("zero_flag", 32'(zero), 32'(acc == '0));
    chk("neg_flag", 32'(neg), 32'(acc[N-1]));
    @(negedge clk);
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_hold", 32'(result), 32'(acc));
  endtask

  initial begin
    int saved;
    rst = 1'b1; start = 1'b0; num_ops = '0;
    op_if.op_valid = 1'b0; op_if.op_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(result), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(op_if.op_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("cin_tied", 32'(sum_cin), 0);
    rst = 1'b0;

    ops_q = '{4'd2, 4'd3, 4'd4};           run(3, 0);
    chk("t2_result", 32'(result), 32'b1001);
    ops_q = '{4'd15, 4'd11};               run(2, 2);
    chk("t3_result", 32'(result), 32'b1010);
    ops_q = '{4'd8, 4'd8};                 run(2, 0);
    chk("t4_zero", 32'(zero), 1);
    ops_q = '{};                           run(0, 0);
    chk("t5_result", 32'(result), 0);
    ops_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    run(12, 0);
    chk("clamp_result", 32'(result), 32'(4'd4));

    for (int r = 0; r < 6; r++) begin
      ops_q = '{};
      for (int i = 0; i < MAX_OPS; i++) ops_q.push_back(N'($urandom_range(0, 15)));
      run($urandom_range(1, MAX_OPS), $urandom_range(0, 3));
    end

    // Aborted run: stray start mid-run is ignored, reset wins, no done follows.
    @(negedge clk);
    start = 1'b1; num_ops = CW'(3);
    @(negedge clk);
    start = 1'b0; op_if.op_valid = 1'b1; op_if.op_data = 4'd5;
    @(negedge clk);
    op_if.op_valid = 1'b0;
    chk("ab_acc", 32'(result), 5);
    start = 1'b1; num_ops = CW'(1);
    @(negedge clk);
    start = 1'b0;
    chk("ab_ign_busy", 32'(busy), 1);
    chk("ab_ign_res", 32'(result), 5);
    saved = n_done;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ab_result", 32'(result), 0);
    chk("ab_carry", 32'(carry), 0);
    chk("ab_ovf", 32'(overflow), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_rdy", 32'(op_if.op_ready), 0);
    repeat (4) @(negedge clk);
    chk("ab_nodone", 32'(n_done), 32'(saved));

    chk("sb_drained", 32'(sb.size()), 0);
    chk("done_count", 32'(n_done), 32'(n_runs));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
